// File: rtl/pooling_mode_core.sv
// rtl/pooling_mode_core.sv - per-lane max/average window pooling over a valid/ready beat stream
// Average pooling is compiled in only when POOLING_AVG_EN is defined; otherwise max pooling only.
module pooling_mode_core #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int WIN_MAX    = 16
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic                        INIT,
   output logic                        READY,
   input  logic                        MODE,
   input  logic [3:0]                  SHIFT,
   input  logic [LANES*DATA_WIDTH-1:0] IN_DATA,
   input  logic                        IN_VALID,
   input  logic                        IN_LAST,
   output logic                        IN_READY,
   output logic [LANES*DATA_WIDTH-1:0] OUT_DATA,
   output logic                        OUT_VALID,
   input  logic                        OUT_READY,
   output logic                        OUT_OVF
);

`ifdef POOLING_AVG_EN
   localparam int GUARD = $clog2(WIN_MAX);
   localparam int ACC_W = DATA_WIDTH + GUARD;
`else
   localparam int ACC_W = DATA_WIDTH;
`endif
   localparam int CNT_W = $clog2(WIN_MAX + 1);

   typedef enum logic {ST_FIRST, ST_ACCUM} state_t;

   state_t                        state_q;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          ovf_q, ovf_d;
   logic signed [ACC_W-1:0]       acc_q [LANES];
   logic signed [ACC_W-1:0]       acc_d [LANES];
   logic signed [ACC_W-1:0]       ext   [LANES];
   logic [LANES*DATA_WIDTH-1:0]   res_d, out_data_q;
   logic                          out_valid_q, out_ovf_q, ready_q;
   logic                          accept, first, cnt_full;

   assign IN_READY  = (!out_valid_q || OUT_READY) && !INIT;
   assign accept    = IN_VALID && IN_READY;
   assign first     = (state_q == ST_FIRST);
   assign cnt_full  = (cnt_q == CNT_W'(WIN_MAX));
   assign ovf_d     = !first && (ovf_q || cnt_full);
   assign cnt_d     = first ? CNT_W'(1) : (cnt_full ? cnt_q : cnt_q + CNT_W'(1));

   assign READY     = ready_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_OVF   = out_ovf_q;

`ifdef POOLING_AVG_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(GUARD+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(GUARD+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic                    mode_q;
   logic [3:0]              shift_q;
   logic                    avg;
   logic [3:0]              shamt;
   logic signed [ACC_W-1:0] avg_sh [LANES];

   // The first beat of a window uses the live MODE/SHIFT; later beats use the latched copy.
   assign avg   = first ? MODE  : mode_q;
   assign shamt = first ? SHIFT : shift_q;
`else
   wire unused_cfg = MODE ^ (^SHIFT);
`endif

   always_comb begin
      res_d = '0;
      for (int k = 0; k < LANES; k++) begin
         ext[k] = ACC_W'($signed(IN_DATA[k*DATA_WIDTH +: DATA_WIDTH]));
         if (first)
            acc_d[k] = ext[k];
`ifdef POOLING_AVG_EN
         else if (avg)
            acc_d[k] = acc_q[k] + ext[k];
`endif
         else if (ext[k] > acc_q[k])
            acc_d[k] = ext[k];
         else
            acc_d[k] = acc_q[k];

`ifdef POOLING_AVG_EN
         avg_sh[k] = acc_d[k] >>> shamt;
         if (!avg)
            res_d[k*DATA_WIDTH +: DATA_WIDTH] = acc_d[k][DATA_WIDTH-1:0];
         else if (avg_sh[k] > SAT_MAX)
            res_d[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
         else if (avg_sh[k] < SAT_MIN)
            res_d[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
         else
            res_d[k*DATA_WIDTH +: DATA_WIDTH] = avg_sh[k][DATA_WIDTH-1:0];
`else
         res_d[k*DATA_WIDTH +: DATA_WIDTH] = acc_d[k];
`endif
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_FIRST;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ovf_q   <= 1'b0;
         ready_q     <= 1'b0;
         for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
`ifdef POOLING_AVG_EN
         mode_q      <= 1'b0;
         shift_q     <= '0;
`endif
      end else if (INIT) begin
         state_q     <= ST_FIRST;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ovf_q   <= 1'b0;
         ready_q     <= 1'b0;
         for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
`ifdef POOLING_AVG_EN
         mode_q      <= 1'b0;
         shift_q     <= '0;
`endif
      end else begin
         ready_q <= 1'b1;
         if (OUT_READY)
            out_valid_q <= 1'b0;
         if (accept) begin
            if (IN_LAST) begin
               // Accepting a last beat while the previous result drains keeps OUT_VALID high.
               out_valid_q <= 1'b1;
               out_data_q  <= res_d;
               out_ovf_q   <= ovf_d;
               state_q     <= ST_FIRST;
               cnt_q       <= '0;
               ovf_q       <= 1'b0;
            end else begin
               for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
               cnt_q   <= cnt_d;
               ovf_q   <= ovf_d;
               state_q <= ST_ACCUM;
`ifdef POOLING_AVG_EN
               if (first) begin
                  mode_q  <= MODE;
                  shift_q <= SHIFT;
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_pooling_mode_core.sv
// tb/tb_pooling_mode_core.sv - scoreboard bench for pooling_mode_core (LANES=4, DATA_WIDTH=16, WIN_MAX=4)
module tb_pooling_mode_core;
   localparam int DW = 16;
   localparam int LN = 4;
   localparam int WM = 4;

   logic        CLK = 1'b0, RESET_N = 1'b0, INIT = 1'b0, MODE = 1'b0;
   logic        IN_VALID = 1'b0, IN_LAST = 1'b0, OUT_READY = 1'b1;
   logic [3:0]  SHIFT = 4'd0;
   logic [63:0] IN_DATA = '0;
   logic        READY, IN_READY, OUT_VALID, OUT_OVF;
   logic [63:0] OUT_DATA;

   int checks = 0, errors = 0, pops = 0, cyc = 0;
   logic [63:0] exp_data[$];
   logic        exp_ovf[$];
   logic [63:0] win[$];
   logic [63:0] mon_ed;
   logic        mon_eo;

   pooling_mode_core #(.DATA_WIDTH(DW), .LANES(LN), .WIN_MAX(WM)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .INIT(INIT), .READY(READY),
      .MODE(MODE), .SHIFT(SHIFT), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
      .IN_LAST(IN_LAST), .IN_READY(IN_READY), .OUT_DATA(OUT_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OVF(OUT_OVF)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (RESET_N && OUT_VALID && OUT_READY) begin
         checks++;
         if (exp_data.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output data=%h ovf=%b required no output", OUT_DATA, OUT_OVF);
         end else begin
            mon_ed = exp_data.pop_front();
            mon_eo = exp_ovf.pop_front();
            pops++;
            if (OUT_DATA !== mon_ed || OUT_OVF !== mon_eo) begin
               errors++;
               $display("FAIL scoreboard data=%h ovf=%b required data=%h ovf=%b", OUT_DATA, OUT_OVF, mon_ed, mon_eo);
            end
         end
      end
   end

   function automatic logic avg_on(input logic m);
`ifdef POOLING_AVG_EN
      return m;
`else
      return 1'b0 & m;
`endif
   endfunction

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [63:0] model(input logic m, input logic [3:0] sh);
      logic [63:0] r;
      logic [63:0] w;
      r = '0;
      for (int l = 0; l < LN; l++) begin
         int acc;
         int v;
         acc = 0;
         for (int b = 0; b < win.size(); b++) begin
            w = win[b];
            v = int'($signed(w[l*DW +: DW]));
            if (b == 0) acc = v;
            else if (avg_on(m)) acc = acc + v;
            else if (v > acc) acc = v;
         end
         if (avg_on(m)) begin
            acc = acc >>> sh;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
         end
         r[l*DW +: DW] = 16'(acc);
      end
      return r;
   endfunction

   task automatic send_beat(input logic [63:0] d, input logic last);
      int n;
      n = 0;
      IN_DATA = d;
      IN_LAST = last;
      IN_VALID = 1'b1;
      @(negedge CLK);
      while (!IN_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!IN_READY) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout in_ready=%b required 1", IN_READY);
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_LAST = 1'b0;
   endtask

   // Beat 0 carries the intended MODE/SHIFT; later beats carry different values that must be ignored.
   task automatic send_window(input logic m, input logic [3:0] sh);
      exp_data.push_back(model(m, sh));
      exp_ovf.push_back(win.size() > WM);
      for (int b = 0; b < win.size(); b++) begin
         MODE  = (b == 0) ? m : !m;
         SHIFT = (b == 0) ? sh : sh + 4'd1;
         send_beat(win[b], b == win.size() - 1);
      end
      MODE = 1'b0;
      SHIFT = 4'd0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_data.size() != 0 && n < 50) begin
         @(posedge CLK);
         #1;
         n++;
      end
      checks++;
      if (exp_data.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", exp_data.size());
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (READY !== 1'b0 || OUT_VALID !== 1'b0 || OUT_DATA !== 64'd0 || OUT_OVF !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs ready=%b valid=%b data=%h ovf=%b required all 0", READY, OUT_VALID, OUT_DATA, OUT_OVF);
      end
      RESET_N = 1'b1;
      #1;
      checks++;
      if (READY !== 1'b0) begin
         errors++;
         $display("FAIL ready_early ready=%b required 0", READY);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (READY !== 1'b1 || IN_READY !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset ready=%b in_ready=%b required 1 1", READY, IN_READY);
      end
   endtask

   task automatic test_max_basic();
      OUT_READY = 1'b1;
      win = '{pk(3, 10, -1, 0), pk(-7, 20, -2, 0), pk(9, 5, -3, 0), pk(2, 1, -4, 0)};
      exp_data.push_back(model(1'b0, 4'd0));
      exp_ovf.push_back(1'b0);
      MODE = 1'b0;
      for (int b = 0; b < 4; b++) begin
         send_beat(win[b], b == 3);
         if (b < 3) begin
            checks++;
            if (OUT_VALID !== 1'b0) begin
               errors++;
               $display("FAIL non_last_output beat=%0d valid=%b required 0", b, OUT_VALID);
            end
         end
      end
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA[15:0] !== 16'd9 || OUT_OVF !== 1'b0) begin
         errors++;
         $display("FAIL max_latency valid=%b lane0=%0d ovf=%b required 1 9 0", OUT_VALID, $signed(OUT_DATA[15:0]), OUT_OVF);
      end
      drain();
   endtask

   task automatic test_max_neg();
      win = '{pk(-32768, -32768, -32768, -32768), pk(-5, -5, -5, -5), pk(-32768, -32768, -32768, -32768)};
      send_window(1'b0, 4'd0);
      checks++;
      if (OUT_DATA !== 64'hFFFB_FFFB_FFFB_FFFB) begin
         errors++;
         $display("FAIL max_negative data=%h required fffbfffbfffbfffb", OUT_DATA);
      end
      win = '{pk(-32768, -32768, -32768, -32768)};
      send_window(1'b0, 4'd0);
      checks++;
      if (OUT_DATA !== 64'h8000_8000_8000_8000) begin
         errors++;
         $display("FAIL single_beat data=%h required 8000800080008000", OUT_DATA);
      end
      drain();
   endtask

   task automatic test_avg();
      logic [15:0] exp0;
`ifdef POOLING_AVG_EN
      exp0 = 16'd5;
`else
      exp0 = 16'd12;
`endif
      win = '{pk(4, -1, 0, 100), pk(8, -2, 0, 100), pk(-4, -3, 0, 100), pk(12, -4, 0, 100)};
      send_window(1'b1, 4'd2);
      checks++;
      if (OUT_DATA[15:0] !== exp0) begin
         errors++;
         $display("FAIL avg_lane0 got=%0d required %0d", $signed(OUT_DATA[15:0]), $signed(exp0));
      end
      win = '{pk(32767, 32767, 32767, -32768), pk(32767, 32767, 32767, -32768),
              pk(32767, 32767, 32767, -32768), pk(32767, 32767, 32767, -32768)};
      send_window(1'b1, 4'd0);
      win = '{pk(-7, 7, -1, 1)};
      send_window(1'b1, 4'd1);
      drain();
   endtask

   task automatic test_backpressure();
      logic [63:0] held;
      OUT_READY = 1'b0;
      win = '{pk(11, 22, 33, 44)};
      send_window(1'b0, 4'd0);
      held = OUT_DATA;
      IN_DATA = pk(1, 1, 1, 1);
      IN_LAST = 1'b1;
      IN_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checks++;
         if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_DATA !== held || OUT_DATA !== pk(11, 22, 33, 44)) begin
            errors++;
            $display("FAIL stall cycle=%0d in_ready=%b valid=%b data=%h required 0 1 %h", i, IN_READY, OUT_VALID, OUT_DATA, pk(11, 22, 33, 44));
         end
      end
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_LAST = 1'b0;
      OUT_READY = 1'b1;
      drain();
   endtask

   task automatic test_back_to_back();
      int beats, c0, p0;
      beats = 0;
      OUT_READY = 1'b1;
      c0 = cyc;
      p0 = pops;
      for (int w = 0; w < 12; w++) begin
         int len;
         len = (w < 4) ? 1 : $urandom_range(1, 4);
         win.delete();
         for (int b = 0; b < len; b++) win.push_back({$urandom(), $urandom()});
         beats += len;
         send_window(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)));
      end
      checks++;
      if (cyc - c0 !== beats) begin
         errors++;
         $display("FAIL throughput cycles=%0d required %0d", cyc - c0, beats);
      end
      drain();
      checks++;
      if (pops - p0 !== 12) begin
         errors++;
         $display("FAIL result_count got=%0d required 12", pops - p0);
      end
   endtask

   task automatic test_overflow();
      win = '{pk(1, 9, -3, 0), pk(2, 8, -3, 0), pk(3, 7, -3, 0), pk(4, 6, -3, 0), pk(5, 5, -3, 0), pk(6, 4, -3, 1)};
      send_window(1'b0, 4'd0);
      checks++;
      if (OUT_OVF !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got=%b required 1", OUT_OVF);
      end
      win = '{pk(10, 20, 30, 40), pk(-10, -20, -30, -40)};
      send_window(1'b0, 4'd0);
      checks++;
      if (OUT_OVF !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got=%b required 0", OUT_OVF);
      end
      drain();
   endtask

   task automatic test_init();
      OUT_READY = 1'b1;
      send_beat(pk(1000, 1000, 1000, 1000), 1'b0);
      send_beat(pk(900, 900, 900, 900), 1'b0);
      INIT = 1'b1;
      #1;
      checks++;
      if (IN_READY !== 1'b0) begin
         errors++;
         $display("FAIL init_in_ready got=%b required 0", IN_READY);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (OUT_VALID !== 1'b0 || READY !== 1'b0) begin
         errors++;
         $display("FAIL init_clear valid=%b ready=%b required 0 0", OUT_VALID, READY);
      end
      INIT = 1'b0;
      @(posedge CLK);
      #1;
      checks++;
      if (READY !== 1'b1) begin
         errors++;
         $display("FAIL init_ready got=%b required 1", READY);
      end
      win = '{pk(1, 2, 3, 4), pk(5, -6, 7, -8)};
      send_window(1'b0, 4'd0);
      checks++;
      if (OUT_DATA !== pk(5, 2, 7, 4)) begin
         errors++;
         $display("FAIL init_discard data=%h required %h", OUT_DATA, pk(5, 2, 7, 4));
      end
      drain();
   endtask

   task automatic test_reset_mid();
      OUT_READY = 1'b0;
      win = '{pk(77, -77, 7, -7)};
      send_window(1'b0, 4'd0);
      RESET_N = 1'b0;
      #1;
      checks++;
      if (READY !== 1'b0 || OUT_VALID !== 1'b0 || OUT_DATA !== 64'd0 || OUT_OVF !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ready=%b valid=%b data=%h ovf=%b required all 0", READY, OUT_VALID, OUT_DATA, OUT_OVF);
      end
      exp_data.delete();
      exp_ovf.delete();
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      checks++;
      if (READY !== 1'b1 || OUT_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_recover ready=%b valid=%b required 1 0", READY, OUT_VALID);
      end
   endtask

   initial begin
      test_reset();
      test_max_basic();
      test_max_neg();
      test_avg();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_init();
      test_reset_mid();
      checks++;
      if (exp_data.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected pending=%0d required 0", exp_data.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t required finish before limit", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pooling_mode_core.md
POOLING_MODE_CORE -- requirements
Module: pooling_mode_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per lane, 2's complement signed.
REQ-002 SHALL have parameter LANES, default 4: independent channels processed in parallel.
REQ-003 SHALL have parameter WIN_MAX, default 16: maximum beats per window; GUARD = clog2(WIN_MAX).
REQ-004 SHALL have port CLK  input  1  clock; all state on rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port INIT  input  1  synchronous clear.
REQ-007 SHALL have port READY  output  1  block initialised and usable.
REQ-008 SHALL have port MODE  input  1  0 = max pooling, 1 = average pooling.
REQ-009 SHALL have port SHIFT  input  4  average divisor exponent (divide by 2^SHIFT).
REQ-010 SHALL have port IN_DATA  input  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port IN_VALID / IN_LAST  input  1 each  beat valid; last beat of window.
REQ-012 SHALL have port IN_READY  output  1  beat accepted when IN_VALID & IN_READY.
REQ-013 SHALL have port OUT_DATA  output  LANES*DATA_WIDTH  pooled result, same lane packing.
REQ-014 SHALL have port OUT_VALID  output  1  result valid; held until OUT_READY.
REQ-015 SHALL have port OUT_READY  input  1  downstream accepts.
REQ-016 SHALL have port OUT_OVF  output  1  window exceeded WIN_MAX beats; qualified by OUT_VALID.

Function
REQ-017 SHALL drive IN_READY = !OUT_VALID | OUT_READY, combinationally, and 0 while INIT=1.
REQ-018 SHALL use two states: FIRST (next accepted beat opens a window) and ACCUM (window open).
REQ-019 SHALL, on an accepted beat in FIRST, load each lane accumulator with the sign-extended lane data, set count=1, latch MODE and SHIFT, go to ACCUM unless IN_LAST.
REQ-020 SHALL, on an accepted beat in ACCUM, update per lane: max mode acc = max(acc, data) signed, ties keep acc; avg mode acc = acc + data at DATA_WIDTH+GUARD bits.
REQ-021 SHALL ignore MODE/SHIFT changes after the first beat of a window.
REQ-022 SHALL, on an accepted IN_LAST beat, register the result including that beat, assert OUT_VALID next cycle (latency 1), return to FIRST.
REQ-023 SHALL treat a single-beat window (IN_LAST on FIRST) as result = data (avg: data >>> SHIFT).
REQ-024 SHALL compute avg result as arithmetic right shift of the sum by SHIFT, saturated to signed DATA_WIDTH range.
REQ-025 SHALL saturate count at WIN_MAX; when a beat arrives with count=WIN_MAX, set sticky overflow, continue accumulating with wrapping sum, and report it on OUT_OVF with the window result.
REQ-026 SHALL drop OUT_VALID on OUT_VALID & OUT_READY unless a new IN_LAST beat is accepted the same cycle, in which case OUT_VALID stays 1 with new data (full throughput).
REQ-027 SHALL hold OUT_DATA and OUT_OVF stable while OUT_VALID=1 and OUT_READY=0.
REQ-028 SHALL emit no output for non-last beats.

Reset
REQ-029 SHALL, on RESET_N=0, clear READY, OUT_VALID, OUT_OVF, OUT_DATA, accumulators, count, go to FIRST.
REQ-030 SHALL, on INIT=1 at a clock edge, apply the same clear; a partial window is discarded.
REQ-031 SHALL set READY=1 one cycle after RESET_N=1 and INIT=0.

Configuration
REQ-032 SHALL compile average mode only when macro POOLING_AVG_EN is defined; otherwise MODE and SHIFT are ignored, adders absent, behaviour is max pooling only.

Verification
REQ-033 SHALL test: LANES=4, MODE=0, window lane0 {3,-7,9,2} -> one output lane0=9, OUT_OVF=0, 1 cycle after last.
REQ-034 SHALL test: all lanes {-32768,-5,-32768} max -> -5; single-beat window 0x8000 -> 0x8000.
REQ-035 SHALL test (POOLING_AVG_EN): MODE=1, SHIFT=2, {4,8,-4,12} -> 5; {32767 x4}, SHIFT=0 -> 32767 saturated.
REQ-036 SHALL test: OUT_READY=0 for 5 cycles with result pending -> IN_READY=0, OUT_DATA stable; back-to-back windows with OUT_READY=1 -> one result per window, no bubbles.
REQ-037 SHALL test: WIN_MAX=4, 6-beat window -> OUT_OVF=1; next 2-beat window -> OUT_OVF=0.
REQ-038 SHALL test: INIT pulse mid-window -> OUT_VALID=0, next window result excludes pre-INIT beats; RESET_N low mid-output -> all outputs 0.
